// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO FIFO pair: FDEBUG bit layout and FIFO join modes.
package pio_pkg;

    localparam int unsigned DefaultDepth = 4;

    localparam int unsigned FdbgTxStall = 3;
    localparam int unsigned FdbgTxOver  = 2;
    localparam int unsigned FdbgRxUnder = 1;
    localparam int unsigned FdbgRxStall = 0;

    typedef enum logic [1:0] {JoinNone, JoinTx, JoinRx} join_mode_e;

    // TX join takes priority when both join bits are set.
    function automatic join_mode_e join_mode(logic fjoin_tx, logic fjoin_rx);
        if (fjoin_tx) return JoinTx;
        if (fjoin_rx) return JoinRx;
        return JoinNone;
    endfunction

endpackage

// File: rtl/pio_fifo_pair_if.sv
// Bus/state-machine facing signal bundle of the PIO FIFO pair.
interface pio_fifo_pair_if import pio_pkg::*; #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DefaultDepth
);
    localparam int unsigned LevelW = $clog2(2 * DEPTH) + 1;

    logic              fjoin_tx;
    logic              fjoin_rx;
    logic              tx_push;
    logic [DATA_W-1:0] tx_wdata;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_rdata;
    logic              sm_pull;
    logic [DATA_W-1:0] sm_pull_data;
    logic              sm_pull_valid;
    logic              sm_push;
    logic [DATA_W-1:0] sm_push_data;
    logic              sm_push_ready;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic [LevelW-1:0] tx_level;
    logic [LevelW-1:0] rx_level;
    logic [3:0]        fdebug;
    logic [3:0]        fdebug_clr;
    logic              irq_rxnempty;
    logic              irq_txnfull;

    modport master (
        output fjoin_tx, fjoin_rx, tx_push, tx_wdata, rx_pop, sm_pull, sm_push, sm_push_data,
               fdebug_clr,
        input  rx_rdata, sm_pull_data, sm_pull_valid, sm_push_ready, tx_full, tx_empty,
               rx_full, rx_empty, tx_level, rx_level, fdebug, irq_rxnempty, irq_txnfull
    );

    modport slave (
        input  fjoin_tx, fjoin_rx, tx_push, tx_wdata, rx_pop, sm_pull, sm_push, sm_push_data,
               fdebug_clr,
        output rx_rdata, sm_pull_data, sm_pull_valid, sm_push_ready, tx_full, tx_empty,
               rx_full, rx_empty, tx_level, rx_level, fdebug, irq_rxnempty, irq_txnfull
    );

endinterface

// File: rtl/pio_fifo_ctrl.sv
// Pointer/level bookkeeping for one FIFO whose capacity can change at run time (0..2*DEPTH).
module pio_fifo_ctrl #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(2 * DEPTH),
    localparam int unsigned LW = PW + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [LW-1:0] cap_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [PW-1:0] rd_ptr_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          push_acc_o,
    output logic          overflow_o,
    output logic          underflow_o
);
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;
    logic          pop_acc;

    function automatic logic [PW-1:0] bump(logic [PW-1:0] ptr, logic [LW-1:0] cap);
        if ({1'b0, ptr} == cap - LW'(1)) return '0;
        return ptr + PW'(1);
    endfunction

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == cap_i);

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign pop_acc     = pop_i && !empty_o && !flush_i;
    assign push_acc_o  = push_i && !flush_i && (cap_i != '0) && (!full_o || pop_acc);
    assign overflow_o  = push_i && !flush_i && !push_acc_o;
    assign underflow_o = pop_i && !flush_i && empty_o;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            level_d = '0;
        end else begin
            if (push_acc_o) wr_d = bump(wr_q, cap_i);
            if (pop_acc)    rd_d = bump(rd_q, cap_i);
            level_d = level_q + LW'(push_acc_o) - LW'(pop_acc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

    assign rd_ptr_o = rd_q;
    assign wr_ptr_o = wr_q;
    assign level_o  = level_q;

endmodule

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair sharing one 2*DEPTH word array, with run-time joining, FSTAT/FDEBUG and IRQs.
module pio_fifo_pair import pio_pkg::*; #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DefaultDepth
) (
    input logic            clk,
    input logic            reset,
    pio_fifo_pair_if.slave bus
);
    localparam int unsigned PW = $clog2(2 * DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DATA_W-1:0] mem_q [2*DEPTH];

    join_mode_e mode_q, mode_in;
    logic       flush;
    logic [LW-1:0] tx_cap, rx_cap;
    logic [PW-1:0] rx_base;

    logic [PW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic          tx_push_acc, tx_over, tx_under;
    logic          rx_push_acc, rx_over, rx_under;
    logic [3:0]    fdebug_q, fdebug_d, fdebug_set;

    // A mode change empties both FIFOs; ops in that cycle are swallowed by the flush.
    assign mode_in = join_mode(bus.fjoin_tx, bus.fjoin_rx);
    assign flush   = (mode_in != mode_q);

    always_comb begin
        tx_cap  = LW'(DEPTH);
        rx_cap  = LW'(DEPTH);
        rx_base = PW'(DEPTH);
        case (mode_q)
            JoinTx: begin
                tx_cap = LW'(2 * DEPTH);
                rx_cap = '0;
            end
            JoinRx: begin
                tx_cap  = '0;
                rx_cap  = LW'(2 * DEPTH);
                rx_base = '0;
            end
            default: ;
        endcase
    end

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_tx_ctrl (
        .clk_i      (clk),
        .reset_i    (reset),
        .cap_i      (tx_cap),
        .push_i     (bus.tx_push),
        .pop_i      (bus.sm_pull),
        .flush_i    (flush),
        .rd_ptr_o   (tx_rd),
        .wr_ptr_o   (tx_wr),
        .level_o    (bus.tx_level),
        .full_o     (bus.tx_full),
        .empty_o    (bus.tx_empty),
        .push_acc_o (tx_push_acc),
        .overflow_o (tx_over),
        .underflow_o(tx_under)
    );

    pio_fifo_ctrl #(.DEPTH(DEPTH)) u_rx_ctrl (
        .clk_i      (clk),
        .reset_i    (reset),
        .cap_i      (rx_cap),
        .push_i     (bus.sm_push),
        .pop_i      (bus.rx_pop),
        .flush_i    (flush),
        .rd_ptr_o   (rx_rd),
        .wr_ptr_o   (rx_wr),
        .level_o    (bus.rx_level),
        .full_o     (bus.rx_full),
        .empty_o    (bus.rx_empty),
        .push_acc_o (rx_push_acc),
        .overflow_o (rx_over),
        .underflow_o(rx_under)
    );

    always_ff @(posedge clk) begin
        if (tx_push_acc) mem_q[tx_wr] <= bus.tx_wdata;
        if (rx_push_acc) mem_q[rx_base + rx_wr] <= bus.sm_push_data;
    end

    always_comb begin
        fdebug_set              = '0;
        fdebug_set[FdbgTxStall] = tx_under;
        fdebug_set[FdbgTxOver]  = tx_over;
        fdebug_set[FdbgRxUnder] = rx_under;
        fdebug_set[FdbgRxStall] = rx_over;
        fdebug_d = (fdebug_q & ~bus.fdebug_clr) | fdebug_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= JoinNone;
            fdebug_q <= '0;
        end else begin
            mode_q   <= mode_in;
            fdebug_q <= fdebug_d;
        end
    end

    assign bus.sm_pull_data  = bus.tx_empty ? '0 : mem_q[tx_rd];
    assign bus.rx_rdata      = bus.rx_empty ? '0 : mem_q[rx_base + rx_rd];
    assign bus.sm_pull_valid = !bus.tx_empty;
    assign bus.sm_push_ready = !bus.rx_full;
    assign bus.irq_rxnempty  = !bus.rx_empty;
    assign bus.irq_txnfull   = !bus.tx_full;
    assign bus.fdebug        = fdebug_q;

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pio_fifo_pair;
    localparam int unsigned DW = 32;
    localparam int unsigned D  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pio_fifo_pair_if #(.DATA_W(DW), .DEPTH(D)) bus ();

    pio_fifo_pair #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues, mode as 0=none 1=tx-joined 2=rx-joined.
    logic [DW-1:0] txq [$];
    logic [DW-1:0] rxq [$];
    int            mode_m = 0;
    logic [3:0]    fdbg_m = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tx_cap_of(int m);
        return (m == 1) ? 2 * D : (m == 2) ? 0 : D;
    endfunction

    function automatic int rx_cap_of(int m);
        return (m == 2) ? 2 * D : (m == 1) ? 0 : D;
    endfunction

    task automatic check_model();
        int tc = tx_cap_of(mode_m);
        int rc = rx_cap_of(mode_m);
        check_eq("tx_level", 32'(bus.tx_level), txq.size());
        check_eq("rx_level", 32'(bus.rx_level), rxq.size());
        check_eq("tx_empty", 32'(bus.tx_empty), 32'(txq.size() == 0));
        check_eq("rx_empty", 32'(bus.rx_empty), 32'(rxq.size() == 0));
        check_eq("tx_full", 32'(bus.tx_full), 32'(txq.size() == tc));
        check_eq("rx_full", 32'(bus.rx_full), 32'(rxq.size() == rc));
        check_eq("sm_pull_data", bus.sm_pull_data, (txq.size() > 0) ? txq[0] : 32'h0);
        check_eq("rx_rdata", bus.rx_rdata, (rxq.size() > 0) ? rxq[0] : 32'h0);
        check_eq("fdebug", 32'(bus.fdebug), 32'(fdbg_m));
        check_eq("irq_txnfull", 32'(bus.irq_txnfull), 32'(txq.size() != tc));
        check_eq("irq_rxnempty", 32'(bus.irq_rxnempty), 32'(rxq.size() != 0));
    endtask

    task automatic model_step(input bit rst, input bit txp, input logic [DW-1:0] txd,
                              input bit pull, input bit smp, input logic [DW-1:0] smd,
                              input bit pop, input logic [3:0] clr);
        int m_in = bus.fjoin_tx ? 1 : (bus.fjoin_rx ? 2 : 0);
        int tc = tx_cap_of(mode_m);
        int rc = rx_cap_of(mode_m);
        logic [3:0] set = '0;
        bit pull_ok, push_ok, pop_ok, smp_ok;
        if (rst) begin
            txq.delete();
            rxq.delete();
            mode_m = 0;
            fdbg_m = '0;
            return;
        end
        if (m_in != mode_m) begin
            txq.delete();
            rxq.delete();
            mode_m = m_in;
            fdbg_m = fdbg_m & ~clr;
            return;
        end
        pull_ok = pull && txq.size() > 0;
        push_ok = txp && tc > 0 && (txq.size() < tc || pull_ok);
        pop_ok  = pop && rxq.size() > 0;
        smp_ok  = smp && rc > 0 && (rxq.size() < rc || pop_ok);
        set[3] = pull && !pull_ok;
        set[2] = txp && !push_ok;
        set[1] = pop && !pop_ok;
        set[0] = smp && !smp_ok;
        if (pull_ok) void'(txq.pop_front());
        if (push_ok) txq.push_back(txd);
        if (pop_ok)  void'(rxq.pop_front());
        if (smp_ok)  rxq.push_back(smd);
        fdbg_m = (fdbg_m & ~clr) | set;
    endtask

    // One clock: apply inputs, compare outputs against the model, clock, advance the model.
    task automatic cycle(input bit txp = 0, input logic [DW-1:0] txd = '0, input bit pull = 0,
                         input bit smp = 0, input logic [DW-1:0] smd = '0, input bit pop = 0,
                         input logic [3:0] clr = '0, input bit rst = 0);
        reset            = rst;
        bus.tx_push      = txp;
        bus.tx_wdata     = txd;
        bus.sm_pull      = pull;
        bus.sm_push      = smp;
        bus.sm_push_data = smd;
        bus.rx_pop       = pop;
        bus.fdebug_clr   = clr;
        check_model();
        @(posedge clk);
        model_step(rst, txp, txd, pull, smp, smd, pop, clr);
        #1;
    endtask

    initial begin
        bus.fjoin_tx = 0;
        bus.fjoin_rx = 0;
        reset = 1;
        @(posedge clk);
        #1;
        cycle(.rst(1));

        check_eq("rst_tx_empty", 32'(bus.tx_empty), 1);
        check_eq("rst_irq_txnfull", 32'(bus.irq_txnfull), 1);
        check_eq("rst_pull_data", bus.sm_pull_data, 0);

        // Fill TX, overflow, drain in order.
        for (int i = 0; i < 4; i++) cycle(.txp(1), .txd(32'hA0 + i));
        check_eq("tx_level_4", 32'(bus.tx_level), 4);
        check_eq("tx_full_4", 32'(bus.tx_full), 1);
        check_eq("irq_txnfull_0", 32'(bus.irq_txnfull), 0);
        cycle(.txp(1), .txd(32'hA4));
        check_eq("txover", 32'(bus.fdebug[2]), 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("pull_order", bus.sm_pull_data, 32'hA0 + i);
            cycle(.pull(1));
        end

        // TX underflow, then W1C of txstall.
        cycle(.pull(1));
        check_eq("pull_valid_0", 32'(bus.sm_pull_valid), 0);
        check_eq("txstall", 32'(bus.fdebug[3]), 1);
        cycle(.clr(4'b1000));
        check_eq("txstall_clr", 32'(bus.fdebug[3]), 0);
        cycle(.clr(4'b1111));

        // RX full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) cycle(.smp(1), .smd(32'hB0 + i));
        check_eq("rx_head_b0", bus.rx_rdata, 32'hB0);
        cycle(.smp(1), .smd(32'h55), .pop(1));
        check_eq("rx_level_4", 32'(bus.rx_level), 4);
        check_eq("rxstall_0", 32'(bus.fdebug[0]), 0);
        for (int i = 0; i < 4; i++) cycle(.pop(1));

        // TX join: 8 accepted, 9th overflows, RX has no capacity.
        bus.fjoin_tx = 1;
        cycle();
        check_eq("jtx_rx_full", 32'(bus.rx_full), 1);
        check_eq("jtx_rx_empty", 32'(bus.rx_empty), 1);
        for (int i = 0; i < 8; i++) cycle(.txp(1), .txd(32'hC0 + i));
        check_eq("jtx_level_8", 32'(bus.tx_level), 8);
        cycle(.txp(1), .txd(32'hC8));
        check_eq("jtx_txover", 32'(bus.fdebug[2]), 1);
        cycle(.smp(1), .smd(32'h99));
        check_eq("jtx_rxstall", 32'(bus.fdebug[0]), 1);

        // Back to unjoined, 2 TX words, then RX join flushes them.
        bus.fjoin_tx = 0;
        cycle(.clr(4'b1111));
        cycle(.txp(1), .txd(32'h1));
        cycle(.txp(1), .txd(32'h2));
        bus.fjoin_rx = 1;
        cycle();
        check_eq("jrx_tx_level_0", 32'(bus.tx_level), 0);
        check_eq("jrx_rx_level_0", 32'(bus.rx_level), 0);
        for (int i = 0; i < 8; i++) cycle(.smp(1), .smd(32'h10 + i));
        for (int i = 0; i < 8; i++) begin
            check_eq("jrx_pop_order", bus.rx_rdata, 32'h10 + i);
            cycle(.pop(1));
        end
        check_eq("jrx_pop_empty_data", bus.rx_rdata, 0);
        cycle(.pop(1));
        check_eq("jrx_rxunder", 32'(bus.fdebug[1]), 1);

        // Reset with both FIFOs half full.
        bus.fjoin_rx = 0;
        cycle();
        for (int i = 0; i < 2; i++) cycle(.txp(1), .txd(32'hD0 + i), .smp(1), .smd(32'hE0 + i));
        cycle(.rst(1));
        check_eq("rst2_tx_level", 32'(bus.tx_level), 0);
        check_eq("rst2_rx_level", 32'(bus.rx_level), 0);
        check_eq("rst2_fdebug", 32'(bus.fdebug), 0);
        check_eq("rst2_rx_empty", 32'(bus.rx_empty), 1);
        check_eq("rst2_irq_rxnempty", 32'(bus.irq_rxnempty), 0);
        check_eq("rst2_irq_txnfull", 32'(bus.irq_txnfull), 1);

        // Random traffic, occasional mode changes, clears and resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] clr;
            if ($urandom_range(0, 59) == 0) begin
                bus.fjoin_tx = 1'($urandom_range(0, 1));
                bus.fjoin_rx = 1'($urandom_range(0, 1));
            end
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cycle(.txp(1'($urandom_range(0, 1))), .txd($urandom),
                  .pull(($urandom_range(0, 2) == 0)),
                  .smp(1'($urandom_range(0, 1))), .smd($urandom),
                  .pop(($urandom_range(0, 2) == 0)), .clr(clr),
                  .rst(($urandom_range(0, 299) == 0)));
        end
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
